// File: rtl/ahbl_splitter_n.sv
// AHB-Lite decoder and response mux for one master and NS slaves, with a built-in
// default slave that gives a two-cycle ERROR response to unmapped transfers.
module ahbl_splitter_n #(
  parameter int NS       = 4,
  parameter int DEC_HI   = 31,
  parameter int DEC_LO   = 28,
  parameter int BASE_IDX = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic             HREADY,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic [NS-1:0]    S_HSEL,
  input  logic [NS*32-1:0] S_HRDATA,
  input  logic [NS-1:0]    S_HREADYOUT,
  input  logic [NS-1:0]    S_HRESP,
  output logic [7:0]       ERR_CNT
);

  localparam int          FW    = DEC_HI - DEC_LO + 1;
  localparam int          IW    = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [31:0] FMASK = 32'((64'd1 << FW) - 64'd1);
  localparam logic [31:0] BASE  = 32'(BASE_IDX);
  localparam logic [31:0] LIMIT = 32'(BASE_IDX + NS);

  typedef enum logic [1:0] {OWN_NONE, OWN_DEF, OWN_SLV} own_e;
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_e;

  logic [31:0]   field_w;
  logic [31:0]   off_w;
  logic          hit_w;
  logic [IW-1:0] slv_idx_w;
  logic          hready_w;

  own_e          dp_kind_q, dp_kind_d;
  logic [IW-1:0] dp_idx_q, dp_idx_d;

  dstate_e       dstate_q;
  logic          def_rdy_q;
  logic          def_resp_q;
  logic [7:0]    err_cnt_q;

  logic          unused_bits;

  // Address decode
  assign field_w   = (HADDR >> DEC_LO) & FMASK;
  assign hit_w     = (field_w >= BASE) && (field_w < LIMIT);
  assign off_w     = field_w - BASE;
  assign slv_idx_w = off_w[IW-1:0];

  assign unused_bits = ^{off_w, HTRANS[0]};

  always_comb begin
    S_HSEL = '0;
    for (int i = 0; i < NS; i++) begin
      S_HSEL[i] = hit_w && (field_w == 32'(BASE_IDX + i));
    end
  end

  // Data-phase owner only advances when the current data phase completes
  always_comb begin
    dp_kind_d = dp_kind_q;
    dp_idx_d  = dp_idx_q;
    if (hready_w) begin
      if (hit_w) begin
        dp_kind_d = OWN_SLV;
        dp_idx_d  = slv_idx_w;
      end else if (HTRANS[1]) begin
        dp_kind_d = OWN_DEF;
        dp_idx_d  = '0;
      end else begin
        dp_kind_d = OWN_NONE;
        dp_idx_d  = '0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_kind_q <= OWN_NONE;
      dp_idx_q  <= '0;
    end else begin
      dp_kind_q <= dp_kind_d;
      dp_idx_q  <= dp_idx_d;
    end
  end

  // Default slave: ERR1 (wait + ERROR) then ERR2 (ready + ERROR)
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dstate_q   <= D_IDLE;
      def_rdy_q  <= 1'b1;
      def_resp_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      case (dstate_q)
        D_ERR1: begin
          dstate_q   <= D_ERR2;
          def_rdy_q  <= 1'b1;
          def_resp_q <= 1'b1;
        end
        default: begin
          if (hready_w && (dp_kind_d == OWN_DEF)) begin
            dstate_q   <= D_ERR1;
            def_rdy_q  <= 1'b0;
            def_resp_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end else begin
            dstate_q   <= D_IDLE;
            def_rdy_q  <= 1'b1;
            def_resp_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Response mux
  always_comb begin
    hready_w = 1'b1;
    HRESP    = 1'b0;
    HRDATA   = '0;
    case (dp_kind_q)
      OWN_SLV: begin
        for (int i = 0; i < NS; i++) begin
          if (dp_idx_q == IW'(i)) begin
            hready_w = S_HREADYOUT[i];
            HRESP    = S_HRESP[i];
            HRDATA   = S_HRDATA[i*32 +: 32];
          end
        end
      end
      OWN_DEF: begin
        hready_w = def_rdy_q;
        HRESP    = def_resp_q;
      end
      default: begin
        hready_w = 1'b1;
      end
    endcase
  end

  assign HREADY  = hready_w;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: mapped reads, wait states, default-slave
// errors, counter saturation and reset during an error response.
module tb_ahbl_splitter_n;

  localparam int NS = 4;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HREADY;
  logic            HRESP;
  logic [31:0]     HRDATA;
  logic [NS-1:0]   S_HSEL;
  logic [NS*32-1:0] S_HRDATA;
  logic [NS-1:0]   S_HREADYOUT;
  logic [NS-1:0]   S_HRESP;
  logic [7:0]      ERR_CNT;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  always #5 HCLK = ~HCLK;

  ahbl_splitter_n #(.NS(NS), .DEC_HI(31), .DEC_LO(28), .BASE_IDX(0)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .S_HSEL      (S_HSEL),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .ERR_CNT     (ERR_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  initial begin
    HRESET      = 1'b1;
    HADDR       = 32'h0;
    HTRANS      = IDLE;
    S_HRDATA    = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};
    S_HREADYOUT = '1;
    S_HRESP     = '0;
    tick();
    tick();
    HRESET = 1'b0;
    smp();
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      32'h0);
    chk("rst_errcnt", 32'(ERR_CNT), 32'd0);

    // 1: single read to slave 2
    tick();
    HADDR  = 32'h2000_0010;
    HTRANS = NONSEQ;
    smp();
    chk("t1_hsel", 32'(S_HSEL), 32'b0100);
    tick();
    HADDR  = 32'h0;
    HTRANS = IDLE;
    smp();
    chk("t1_hrdata", HRDATA,      32'hDEAD_BEEF);
    chk("t1_hready", 32'(HREADY), 32'd1);
    chk("t1_hresp",  32'(HRESP),  32'd0);

    // 2: slave 1 with two wait states, then slave 3
    tick();
    HADDR  = 32'h1000_0000;
    HTRANS = NONSEQ;
    smp();
    chk("t2_hsel_s1", 32'(S_HSEL), 32'b0010);
    tick();
    HADDR          = 32'h3000_0000;
    S_HREADYOUT[1] = 1'b0;
    smp();
    chk("t2_wait1_hready", 32'(HREADY), 32'd0);
    chk("t2_wait1_hsel",   32'(S_HSEL), 32'b1000);
    tick();
    smp();
    chk("t2_wait2_hready", 32'(HREADY), 32'd0);
    chk("t2_wait2_hsel",   32'(S_HSEL), 32'b1000);
    tick();
    S_HREADYOUT[1] = 1'b1;
    smp();
    chk("t2_s1_hready", 32'(HREADY), 32'd1);
    chk("t2_s1_hrdata", HRDATA,      32'h1111_1111);
    chk("t2_s1_hsel",   32'(S_HSEL), 32'b1000);
    tick();
    HADDR  = 32'h0;
    HTRANS = IDLE;
    smp();
    chk("t2_s3_hrdata", HRDATA,      32'h3333_3333);
    chk("t2_s3_hready", 32'(HREADY), 32'd1);

    // 3: unmapped NONSEQ -> two-cycle ERROR
    tick();
    HADDR  = 32'h8000_0000;
    HTRANS = NONSEQ;
    smp();
    chk("t3_hsel", 32'(S_HSEL), 32'b0000);
    tick();
    HTRANS = IDLE;
    smp();
    chk("t3_c1_hready", 32'(HREADY),  32'd0);
    chk("t3_c1_hresp",  32'(HRESP),   32'd1);
    chk("t3_c1_hrdata", HRDATA,       32'h0);
    chk("t3_errcnt",    32'(ERR_CNT), 32'd1);
    tick();
    smp();
    chk("t3_c2_hready", 32'(HREADY), 32'd1);
    chk("t3_c2_hresp",  32'(HRESP),  32'd1);

    // 4: unmapped IDLE completes at once with OKAY
    tick();
    smp();
    chk("t4_hready", 32'(HREADY),  32'd1);
    chk("t4_hresp",  32'(HRESP),   32'd0);
    chk("t4_errcnt", 32'(ERR_CNT), 32'd1);

    // 5: 260 back-to-back unmapped NONSEQ, counter saturates
    HTRANS = NONSEQ;
    for (int k = 0; k < 260; k++) begin
      tick();
      smp();
      chk("t5_c1_hready", 32'(HREADY),  32'd0);
      chk("t5_errcnt",    32'(ERR_CNT), (k + 2 > 255) ? 32'd255 : 32'(k + 2));
      tick();
      if (k == 259) HTRANS = IDLE;
      smp();
      chk("t5_c2_hready", 32'(HREADY), 32'd1);
      chk("t5_c2_hresp",  32'(HRESP),  32'd1);
    end
    tick();
    smp();
    chk("t5_end_hready", 32'(HREADY),  32'd1);
    chk("t5_end_hresp",  32'(HRESP),   32'd0);
    chk("t5_end_errcnt", 32'(ERR_CNT), 32'd255);

    // 6: reset in the middle of ERR1, then a normal read
    HTRANS = NONSEQ;
    tick();
    smp();
    chk("t6_err1_hready", 32'(HREADY),  32'd0);
    chk("t6_err1_errcnt", 32'(ERR_CNT), 32'd255);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    HADDR  = 32'h2000_0000;
    HTRANS = NONSEQ;
    smp();
    chk("t6_rst_hready", 32'(HREADY),  32'd1);
    chk("t6_rst_hresp",  32'(HRESP),   32'd0);
    chk("t6_rst_errcnt", 32'(ERR_CNT), 32'd0);
    tick();
    HADDR  = 32'h3000_0000;
    smp();
    chk("t6_rd_hrdata", HRDATA,       32'hDEAD_BEEF);
    chk("t6_rd_hready", 32'(HREADY),  32'd1);
    chk("t6_rd_hresp",  32'(HRESP),   32'd0);

    // Slave ERROR response is passed through
    S_HRESP[3] = 1'b1;
    tick();
    HTRANS = IDLE;
    HADDR  = 32'h0;
    smp();
    chk("slv_hresp",  32'(HRESP),   32'd1);
    chk("slv_errcnt", 32'(ERR_CNT), 32'd0);
    S_HRESP[3] = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
